// File: rtl/alu16_pkg.sv
// Shared types for the 16-bit ALU sequencer: FSM state, op codes, requester id.
// Imported by the interface, the arbiter and the top.
package alu16_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef logic [1:0] op_t;
    typedef logic       req_id_t;

    localparam op_t OP_ADD = 2'b00;
    localparam op_t OP_SUB = 2'b01;
    localparam op_t OP_MUL = 2'b10;
    localparam op_t OP_SHR = 2'b11;

endpackage

// File: rtl/alu16_arbiter_if.sv
// Bundle of the two request channels, the ALU operand/result bus and the
// response channel. master = clients + ALU side, slave = the arbiter block.
interface alu16_arbiter_if;
    import alu16_pkg::*;

    logic        req0_valid;
    logic        req0_ready;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    op_t         req0_op;

    logic        req1_valid;
    logic        req1_ready;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    op_t         req1_op;

    logic [15:0] alu_a;
    logic [15:0] alu_b;
    op_t         alu_sel;
    logic [31:0] alu_out;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    req_id_t     rsp_id;
    logic        busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_out,
        input  rsp_valid, rsp_data, rsp_id, busy,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_out,
        output rsp_valid, rsp_data, rsp_id, busy,
        input  rsp_ready
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Ports: clk, reset (sync, active-high),
// en_i (grant allowed), req_i[1:0], gnt_o[1:0] one-hot (combinational).
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    // Index of the most recent winner; reset to 1 so port 0 wins the first tie.
    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            unique case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
    end

    always_comb begin
        last_d = last_q;
        if (|gnt_o) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/alu16_arbiter.sv
// Shares one 16-bit ALU between two requesters: round-robin grant, hold
// operands ALU_LAT cycles, capture the 32-bit result, return it tagged.
// Ports: clk, reset (sync, active-high), bus (alu16_arbiter_if.slave),
// stat_grants0/1 (STAT_W-bit saturating grant counts, only with
// ALU_ARB_STATS_EN defined).
module alu16_arbiter
    import alu16_pkg::*;
#(
    parameter int ALU_LAT = 2,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    alu16_arbiter_if.slave    bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_grants0,
    output logic [STAT_W-1:0] stat_grants1
`endif
);

    if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_lat_chk
        $error("ALU_LAT must be in 1..15");
    end
    if (STAT_W < 1) begin : g_sw_chk
        $error("STAT_W must be at least 1");
    end

    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    op_t         sel_q, sel_d;
    logic [31:0] data_q, data_d;
    req_id_t     id_q, id_d;
    logic [1:0]  gnt;

    // Grants only in IDLE, so the accept cycle of a response never grants.
    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en_i  (state_q == IDLE),
        .req_i ({bus.req1_valid, bus.req0_valid}),
        .gnt_o (gnt)
    );

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_sel    = sel_q;
    assign bus.rsp_data   = data_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.busy       = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        data_d  = data_q;
        id_d    = id_q;
        unique case (state_q)
            IDLE: begin
                if (|gnt) begin
                    state_d = WAIT;
                    cnt_d   = LAT_M1;
                    id_d    = gnt[1];
                    a_d     = gnt[1] ? bus.req1_a  : bus.req0_a;
                    b_d     = gnt[1] ? bus.req1_b  : bus.req0_b;
                    sel_d   = gnt[1] ? bus.req1_op : bus.req0_op;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    data_d  = bus.alu_out;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 16'd0;
            b_q     <= 16'd0;
            sel_q   <= 2'b00;
            data_q  <= 32'd0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            id_q    <= id_d;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [STAT_W-1:0] g0_q, g1_q;

    // Saturate at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            g0_q <= '0;
            g1_q <= '0;
        end else begin
            if (gnt[0] && !(&g0_q)) begin
                g0_q <= g0_q + STAT_W'(1);
            end
            if (gnt[1] && !(&g1_q)) begin
                g1_q <= g1_q + STAT_W'(1);
            end
        end
    end

    assign stat_grants0 = g0_q;
    assign stat_grants1 = g1_q;
`endif

endmodule

// File: doc/alu16_arbiter.md
# alu16_arbiter

Sequencing and sharing controller for the 16-bit ALU. Two independent requesters submit (a, b, op) transactions over valid/ready handshakes. The block arbitrates round-robin, drives the shared ALU operand/select inputs from registers, and waits a fixed settle time. It then captures the 32-bit result and returns it, tagged with the requester ID, over a valid/ready response channel. It sits between the ALU and its client logic, and is the only driver of the ALU inputs.

## Interface
- ALU_LAT, default 2: cycles the ALU inputs are held stable before `alu_out` is sampled. Legal range 1..15.
- STAT_W, default 16: width of the grant counters (present only with the stats feature).
- clk  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-high.
- req0_valid / req1_valid  input  1  requester n has a transaction.
- req0_ready / req1_ready  output  1  requester n's transaction is accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  input  16  operands.
- req0_op / req1_op  input  2  ALU select: 00 add, 01 sub, 10 mult, 11 shift.
- alu_a, alu_b  output  16  registered operands to the ALU.
- alu_sel  output  2  registered select to the ALU.
- alu_out  input  32  ALU result.
- rsp_valid  output  1  a response is held.
- rsp_ready  input  1  the consumer accepts the response.
- rsp_data  output  32  captured result.
- rsp_id  output  1  requester that owns the response.
- busy  output  1  high whenever the state is not IDLE.
- stat_grants0 / stat_grants1  output  STAT_W  grant counts (stats feature only).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If any `reqN_valid` is high, select a winner and assert its `reqN_ready`. Only one ready is ever high.
  - Latch the winner's a, b, op into alu_a/alu_b/alu_sel and its index into rsp_id.
  - Load the wait counter with ALU_LAT-1, then go to WAIT.
- Arbitration:
  - Only one requester valid: that requester wins.
  - Both valid: the requester not granted last wins.
  - The `last` pointer resets to 1, so port 0 wins the first tie.
- WAIT:
  - ALU inputs are held constant. The counter decrements each cycle.
  - In the cycle the counter reads 0: rsp_data <= alu_out, then go to RESP.
- RESP:
  - rsp_valid stays high; rsp_data and rsp_id stay stable until rsp_ready is sampled high.
  - On accept, go to IDLE. No new request is granted in the accept cycle.
- Backpressure: a stalled rsp_ready holds the block in RESP indefinitely. Pending requests wait with valid high.
- Requester rules:
  - A requester must hold valid and its payload stable until ready.
  - Payload changes while valid and not ready are a protocol error; no recovery is defined.
- alu_a/alu_b/alu_sel change only on a grant edge. Between transactions they retain the last values.
- Width: results are passed through unmodified as 32 bits. The block does no arithmetic on data.
- Reset, including mid-operation:
  - The in-flight transaction is discarded and no response is produced.
  - State returns to IDLE; last pointer = 1; counter = 0.
  - All outputs go to 0: reqN_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_id, busy, stat counters.

## Timing
- Accept edge T (ready high in cycle T):
  - ALU inputs are valid from T+1.
  - rsp_data is captured at the end of cycle T+ALU_LAT.
  - rsp_valid is high from T+ALU_LAT+1.
- Minimum accept-to-accept spacing is ALU_LAT+2 cycles, with rsp_ready tied high.
- reqN_ready is combinational from state, the valids and the last pointer. It must not depend on rsp_ready.
- All other outputs are registered.

## Configuration
- ALU_ARB_STATS_EN:
  - Defined: the stat_grants0/1 ports exist. Each increments by 1 on its port's grant and saturates at all-ones (no wrap). Reset clears both.
  - Undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package `alu16_pkg`:
  - FSM state enum.
  - Op encoding constants: OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_SHR=2'b11.
  - Requester ID type.
- One sub-module, `rr_arb2`: 2-way round-robin arbiter with a last-grant register, enable and grant-one-hot output. The wait counter and FSM stay in the top module.

## Test plan
- Single add: port 0 sends a=3, b=5, op=00, ALU_LAT=2. Required: ready in cycle T; rsp_valid at T+3; rsp_data=32'd8; rsp_id=0.
- Mult with backpressure: port 1 sends a=300, b=200, op=10, rsp_ready low for 5 cycles. Required: rsp_data=32'd60000 held stable; busy=1 throughout; release returns to IDLE.
- Tie fairness: both ports continuously send sub (5,3) and add (1,1). Required: grants alternate 0,1,0,1; responses are 2,2,... on id 0 and 2,2,... on id 1; no starvation across 8 transactions.
- Reset mid-operation: assert reset in WAIT. Required: no rsp_valid; all outputs 0 next cycle; the next tie is granted to port 0.
- Stats (ALU_ARB_STATS_EN with STAT_W=2): 5 grants to port 0. Required: stat_grants0=3 (saturated); stat_grants1=0.
- Spacing: back-to-back requests on port 0 with rsp_ready=1. Required: accepts are exactly ALU_LAT+2 cycles apart.
